// File: rtl/alu_writeback.sv
// ALU result writeback stage: 2-entry FIFO toward the register file, status flags and drop counter.
// Optional build macro FLAG_FORWARD_EN forwards newly set flags combinationally.
module alu_writeback #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W:0]   result,
    input  logic [3:0]        flg_in,
    input  logic              s_in,
    input  logic              cond_pass,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [3:0]        flags,
    output logic [7:0]        drop_cnt
);

    logic [ADDR_W-1:0] r_addr [2];
    logic [DATA_W-1:0] r_data [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              r_in_ready;
    logic [3:0]        r_flags;
    logic [7:0]        r_drop_cnt;

    logic       w_accept;
    logic       w_push;
    logic       w_pop;
    logic       w_drop;
    logic       w_set_flags;
    logic       w_wb_valid;
    logic [1:0] w_count_d;
    logic       w_unused_carry;

    // Carry-out is not part of the register-file write.
    assign w_unused_carry = result[DATA_W];

    assign w_wb_valid  = (r_count != 2'd0);
    assign w_accept    = in_valid && r_in_ready;
    assign w_push      = w_accept && cond_pass;
    assign w_drop      = w_accept && !cond_pass;
    assign w_set_flags = w_push && s_in;
    assign w_pop       = w_wb_valid && wb_ready;

    always_comb begin
        w_count_d = r_count;
        if (w_push && !w_pop) begin
            w_count_d = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_count_d = r_count - 2'd1;
        end
    end

    // in_ready is a register so it never depends combinationally on wb_ready,
    // and it stays low for the reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_in_ready <= 1'b0;
            r_flags    <= 4'b0000;
            r_drop_cnt <= 8'd0;
        end else begin
            r_count    <= w_count_d;
            r_in_ready <= (w_count_d < 2'd2);
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_set_flags) begin
                r_flags <= flg_in;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_addr[r_wr_ptr] <= rd_addr;
            r_data[r_wr_ptr] <= result[DATA_W-1:0];
        end
    end

    assign in_ready = r_in_ready;
    assign wb_valid = w_wb_valid;
    assign wb_addr  = w_wb_valid ? r_addr[r_rd_ptr] : '0;
    assign wb_data  = w_wb_valid ? r_data[r_rd_ptr] : '0;
    assign drop_cnt = r_drop_cnt;

`ifdef FLAG_FORWARD_EN
    assign flags = w_set_flags ? flg_in : r_flags;
`else
    assign flags = r_flags;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed table-driven bench for alu_writeback plus hand sequences for saturation and flag timing.
module tb_alu_writeback;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W:0]   result;
    logic [3:0]        flg_in;
    logic              s_in;
    logic              cond_pass;
    logic [ADDR_W-1:0] rd_addr;
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [3:0]        flags;
    logic [7:0]        drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    alu_writeback #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .flg_in    (flg_in),
        .s_in      (s_in),
        .cond_pass (cond_pass),
        .rd_addr   (rd_addr),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .flags     (flags),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record = inputs held across one rising edge, and outputs expected just after it.
    typedef struct {
        logic            rst;
        logic            iv;
        logic [DATA_W:0] res;
        logic [3:0]      flg;
        logic            s;
        logic            cp;
        logic [3:0]      rd;
        logic            wr;
        logic            e_ir;
        logic            e_wv;
        logic [3:0]      e_wa;
        logic [31:0]     e_wd;
        logic [3:0]      e_fl;
        logic [7:0]      e_dc;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic iv, input logic [DATA_W:0] res,
                                input logic [3:0] flg, input logic s, input logic cp,
                                input logic [3:0] rd, input logic wr, input logic ir,
                                input logic wv, input logic [3:0] wa, input logic [31:0] wd,
                                input logic [3:0] fl, input logic [7:0] dc);
        vec_t v;
        v.rst = r;  v.iv = iv;  v.res = res;  v.flg = flg;  v.s = s;  v.cp = cp;
        v.rd = rd;  v.wr = wr;  v.e_ir = ir;  v.e_wv = wv;  v.e_wa = wa;  v.e_wd = wd;
        v.e_fl = fl;  v.e_dc = dc;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [DATA_W:0] res, input logic [3:0] flg,
                         input logic s, input logic cp, input logic [3:0] rd, input logic wr);
        in_valid  = iv;
        result    = res;
        flg_in    = flg;
        s_in      = s;
        cond_pass = cp;
        rd_addr   = rd;
        wb_ready  = wr;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);

        //                rst iv  result          flg  s  cp rd  wr   ir wv wa  wd     fl   dc
        vecs[0]  = mk(1, 0, 33'h0,          4'h0, 0, 0, 0,  1,   0, 0, 0,  32'h0,  4'h0, 0);
        vecs[1]  = mk(0, 0, 33'h0,          4'h0, 0, 0, 0,  1,   1, 0, 0,  32'h0,  4'h0, 0);
        vecs[2]  = mk(0, 1, 33'h1_0000_0005, 4'h0, 0, 1, 3,  1,   1, 1, 3,  32'h5,  4'h0, 0);
        vecs[3]  = mk(0, 0, 33'h0,          4'h0, 0, 0, 0,  1,   1, 0, 0,  32'h0,  4'h0, 0);
        vecs[4]  = mk(0, 1, 33'h33,         4'hF, 1, 0, 5,  1,   1, 0, 0,  32'h0,  4'h0, 1);
        vecs[5]  = mk(0, 1, 33'h33,         4'hF, 1, 0, 5,  1,   1, 0, 0,  32'h0,  4'h0, 2);
        vecs[6]  = mk(0, 1, 33'h33,         4'hF, 1, 0, 5,  1,   1, 0, 0,  32'h0,  4'h0, 3);
        vecs[7]  = mk(0, 1, 33'h11,         4'h4, 1, 1, 1,  1,   1, 1, 1,  32'h11, 4'h4, 3);
        vecs[8]  = mk(0, 1, 33'h22,         4'hF, 0, 1, 2,  1,   1, 1, 2,  32'h22, 4'h4, 3);
        vecs[9]  = mk(0, 0, 33'h0,          4'h0, 0, 0, 0,  1,   1, 0, 0,  32'h0,  4'h4, 3);
        vecs[10] = mk(0, 1, 33'hA,          4'h0, 0, 1, 10, 0,   1, 1, 10, 32'hA,  4'h4, 3);
        vecs[11] = mk(0, 1, 33'hB,          4'h0, 0, 1, 11, 0,   0, 1, 10, 32'hA,  4'h4, 3);
        vecs[12] = mk(0, 1, 33'hC,          4'h0, 0, 1, 12, 0,   0, 1, 10, 32'hA,  4'h4, 3);
        vecs[13] = mk(0, 1, 33'hC,          4'h0, 0, 1, 12, 0,   0, 1, 10, 32'hA,  4'h4, 3);
        vecs[14] = mk(0, 1, 33'hC,          4'h0, 0, 1, 12, 1,   1, 1, 11, 32'hB,  4'h4, 3);
        vecs[15] = mk(0, 1, 33'hC,          4'h0, 0, 1, 12, 1,   1, 1, 12, 32'hC,  4'h4, 3);
        vecs[16] = mk(0, 0, 33'h0,          4'h0, 0, 0, 0,  1,   1, 0, 0,  32'h0,  4'h4, 3);
        vecs[17] = mk(0, 1, 33'h44,         4'hA, 1, 1, 4,  0,   1, 1, 4,  32'h44, 4'hA, 3);
        vecs[18] = mk(0, 1, 33'h55,         4'h0, 0, 1, 5,  0,   0, 1, 4,  32'h44, 4'hA, 3);
        vecs[19] = mk(1, 1, 33'h66,         4'hF, 1, 1, 6,  1,   0, 0, 0,  32'h0,  4'h0, 0);
        vecs[20] = mk(0, 1, 33'h66,         4'hF, 1, 1, 6,  1,   1, 0, 0,  32'h0,  4'h0, 0);
        vecs[21] = mk(0, 0, 33'h0,          4'h0, 0, 0, 0,  1,   1, 0, 0,  32'h0,  4'h0, 0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            drive(vecs[i].iv, vecs[i].res, vecs[i].flg, vecs[i].s, vecs[i].cp, vecs[i].rd,
                  vecs[i].wr);
            @(posedge clk);
            #1;
            check($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
            check($sformatf("v%0d wb_valid", i), 64'(wb_valid), 64'(vecs[i].e_wv));
            check($sformatf("v%0d wb_addr", i),  64'(wb_addr),  64'(vecs[i].e_wa));
            check($sformatf("v%0d wb_data", i),  64'(wb_data),  64'(vecs[i].e_wd));
            check($sformatf("v%0d flags", i),    64'(flags),    64'(vecs[i].e_fl));
            check($sformatf("v%0d drop_cnt", i), 64'(drop_cnt), 64'(vecs[i].e_dc));
        end

        // Drop counter saturation: 300 failed-condition results with set-flags requested.
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            drive(1'b1, 33'h99, 4'hF, 1'b1, 1'b0, 4'h9, 1'b1);
            @(posedge clk);
            #1;
            if (i == 254 || i == 255 || i == 256 || i == 300) begin
                check($sformatf("sat drop_cnt@%0d", i), 64'(drop_cnt),
                      (i > 255) ? 64'd255 : 64'(i));
            end
            if (i == 300) begin
                check("sat wb_valid", 64'(wb_valid), 64'd0);
                check("sat flags", 64'(flags), 64'd0);
            end
        end

        // Flag timing: visible after the accepting edge (same cycle when forwarding is built in).
        @(negedge clk);
        drive(1'b1, 33'h77, 4'h6, 1'b1, 1'b1, 4'h7, 1'b0);
        #1;
`ifdef FLAG_FORWARD_EN
        check("fwd flags same cycle", 64'(flags), 64'h6);
`else
        check("fwd flags same cycle", 64'(flags), 64'h0);
`endif
        @(posedge clk);
        #1;
        check("flags after set", 64'(flags), 64'h6);
        check("wb_data 77", 64'(wb_data), 64'h77);
        @(negedge clk);
        drive(1'b1, 33'h88, 4'h9, 1'b0, 1'b1, 4'h8, 1'b0);
        @(posedge clk);
        #1;
        check("flags s_in=0 kept", 64'(flags), 64'h6);
        check("in_ready full", 64'(in_ready), 64'd0);
        @(negedge clk);
        drive(1'b0, '0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1);
        @(posedge clk);
        #1;
        check("drain head 88", 64'(wb_data), 64'h88);
        check("drain addr 8", 64'(wb_addr), 64'h8);
        @(posedge clk);
        #1;
        check("drain empty", 64'(wb_valid), 64'd0);
        check("drop_cnt held", 64'(drop_cnt), 64'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter DATA_W, default 32, width of register-file write data.
REQ-002 Parameter ADDR_W, default 4, width of destination register address.
REQ-003 Clock is clk and reset is rst; one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  ALU result presented this cycle.
REQ-007 in_ready  output  1  block can accept a result this cycle.
REQ-008 result  input  DATA_W+1  ALU result; bit DATA_W is carry-out.
REQ-009 flg_in  input  4  ALU flag vector for this result, stored verbatim.
REQ-010 s_in  input  1  set-flags request for this result.
REQ-011 cond_pass  input  1  ALU condition evaluated true for this result.
REQ-012 rd_addr  input  ADDR_W  destination register of this result.
REQ-013 wb_valid  output  1  write request to register file pending.
REQ-014 wb_ready  input  1  register file accepts the write this cycle.
REQ-015 wb_addr  output  ADDR_W  write destination, valid when wb_valid.
REQ-016 wb_data  output  DATA_W  write data, result[DATA_W-1:0].
REQ-017 flags  output  4  status register, fed back to the ALU flags input.
REQ-018 drop_cnt  output  8  count of results discarded for failed condition.

Function
REQ-019 Transfer in occurs when in_valid && in_ready; transfer out when wb_valid && wb_ready.
REQ-020 Block SHALL hold a 2-entry FIFO of {rd_addr, result[DATA_W-1:0]}; carry bit SHALL NOT be stored.
REQ-021 in_ready SHALL equal (FIFO count < 2), registered state only, no combinational dependence on wb_ready.
REQ-022 wb_valid SHALL equal (FIFO count != 0); wb_addr/wb_data SHALL present the oldest entry.
REQ-023 Accepted result with cond_pass=1 SHALL be pushed; latency in_valid to wb_valid is 1 cycle when empty.
REQ-024 Accepted result with cond_pass=0 SHALL NOT be pushed and SHALL NOT update flags; drop_cnt SHALL increment, saturating at 255.
REQ-025 Accepted result with cond_pass=1 and s_in=1 SHALL load flags <= flg_in on that edge; s_in=0 leaves flags unchanged.
REQ-026 Simultaneous push and pop at count 1 SHALL keep count 1 with entries in order; at count 2 push is blocked by in_ready=0 and pop SHALL proceed.
REQ-027 Pop at count 0 and push at count 2 SHALL NOT occur (outputs gate them); pointers wrap modulo 2.
REQ-028 wb_addr/wb_data SHALL remain stable while wb_valid=1 and wb_ready=0.
REQ-029 Flags update SHALL occur at input acceptance regardless of FIFO back-pressure on the write side.

Reset
REQ-030 On rst=1 at a clock edge: FIFO count 0, pointers 0, flags 4'b0000, drop_cnt 0.
REQ-031 During reset: in_ready=0, wb_valid=0, wb_addr=0, wb_data=0; in_ready SHALL rise the cycle after rst deasserts.
REQ-032 Reset mid-operation SHALL discard all pending entries without issuing writes; input in reset cycle is ignored.

Configuration
REQ-033 Macro FLAG_FORWARD_EN: when defined, flags SHALL output flg_in combinationally in any cycle with an accepted cond_pass=1, s_in=1 result, else the status register.
REQ-034 Without FLAG_FORWARD_EN, flags SHALL be the status register only (new flags visible one cycle after acceptance); register update is identical in both builds.

Verification
REQ-035 Reset, then push result=33'h1_0000_0005, rd_addr=3, cond_pass=1, wb_ready=1 -> next cycle wb_valid=1, wb_addr=3, wb_data=32'h5.
REQ-036 wb_ready=0, three back-to-back valid results A,B,C -> in_ready=0 after B, C held off; raise wb_ready -> writes A,B then C in order.
REQ-037 cond_pass=0 results x3 with s_in=1, flg_in=4'b1111 -> no wb_valid, flags stay 0, drop_cnt=3; 300 drops -> drop_cnt=255.
REQ-038 s_in=1, flg_in=4'b0100, cond_pass=1 -> flags=4'b0100 next cycle (same cycle with FLAG_FORWARD_EN); s_in=0 follow-up -> flags unchanged.
REQ-039 Two entries pending, assert rst one cycle -> wb_valid=0, no write issued, flags=0, drop_cnt=0, in_ready=1 after release.
